spi_target: RTL and testbench
=============================

# spi_target

SPI mode-0 target (responder) for the HACK I/O map, the counterpart to the `SPI` controller at 4100. It lets an external SPI initiator (a second HACK board, a debug MCU or an RTP/LCD bridge) exchange bytes with software. The block samples the initiator's pins in the `clk` domain through synchronizers. It exposes one 16-bit memory-mapped register with the same read/write shape as the other I/O registers: `out` feeds `Memory` `inIOx`, and `load`/`in` are driven from `writeM`/`outM`.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `SCK`, `CSX`, `SDI` (≥2).
- `IDLE_BYTE`, 8'hFF: byte shifted out when software has not loaded a TX byte.

- `clk`  in  1  internal 25 MHz system clock.
- `resetx`  in  1  reset; one clock; reset is asynchronous and active-low.
- `load`  in  1  memory-mapped write strobe.
- `in`  in  16  write data. `in[8]`=1 clears RX status; `in[8]`=0 loads TX byte `in[7:0]`.
- `out`  out  16  status/data. `[15]`=RX empty, `[14]`=frame active, `[13]`=overrun, `[12]`=TX pending, `[11:8]`=0, `[7:0]`=last received byte.
- `SCK`  in  1  initiator serial clock (pin); idles low.
- `CSX`  in  1  initiator chip select, active low (pin).
- `SDI`  in  1  initiator data to target (MOSI).
- `SDO`  out  1  target data to initiator (MISO).
- `SDO_OE`  out  1  tristate enable for `SDO`; 1 while the frame is active.

## Operation
- Synchronize `SCK`, `CSX` and `SDI` through `SYNC_STAGES` flops. Keep one extra flop on `SCK` and `CSX` for edge detection. Produce one-cycle pulses `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise`.
- State machine:
  - IDLE (synchronized CSX=1) -> ACTIVE on `cs_fall`.
  - ACTIVE -> IDLE on `cs_rise`, from any bit position.
  - SCK edges are ignored in IDLE.
- On `cs_fall`:
  - `bitcnt`<=0.
  - `tx_shift`<= `tx_pending` ? `tx_buf` : `IDLE_BYTE`; clear `tx_pending`.
  - `SDO`<=bit 7 of the loaded byte.
- On `sck_rise` (ACTIVE):
  - `rx_shift`<={`rx_shift[6:0]`, SDI_sync}; `bitcnt`<=`bitcnt`+1 (3-bit, wraps 7->0).
  - When `bitcnt`==7 the byte completes. If RX empty=0 already, set overrun and discard the new byte (keep the old byte). Otherwise `out[7:0]`<= completed byte and RX empty<=0.
- On `sck_fall` (ACTIVE):
  - If `bitcnt`!=0, shift `tx_shift` left and `SDO`<=next bit.
  - If `bitcnt`==0, a byte has just ended. Reload `tx_shift` exactly as on `cs_fall` and drive its MSB. Back-to-back bytes need no CSX toggle.
- `cs_rise` mid-byte:
  - Discard partial RX bits; RX status is unchanged.
  - The in-flight TX byte is consumed, not restored.
  - `bitcnt`<=0; `SDO_OE`<=0.
- Host write `in[8]`=0: `tx_buf`<=`in[7:0]`, `tx_pending`<=1. A second write before consumption overwrites `tx_buf`.
- Host write `in[8]`=1: RX empty<=1, overrun<=0.
- Simultaneous events:
  - Clear and byte completion in the same cycle: clear applies first, then completion. Result: RX empty=0, overrun=0, new byte stored.
  - TX load and reload in the same cycle: the reload uses the previous `tx_buf`/`tx_pending`, and the write then sets `tx_pending`=1 with the new byte.
- Reset values:
  - `out`=16'h8000.
  - `SDO`=1, `SDO_OE`=0.
  - `tx_buf`=`IDLE_BYTE`, `tx_pending`=0, `bitcnt`=0.
  - State IDLE; synchronizer flops reset to SCK=0, CSX=1.
  - Reset mid-frame forces IDLE. The frame is resumed only after CSX goes high, then falls again.

## Timing
- Pin-to-pulse latency is `SYNC_STAGES`+1 clk (3 clk at default).
- `out` updates 1 clk after the pulse. RX byte is visible 4 clk after the 8th SCK rising pin edge.
- Limits on the initiator:
  - SCK high and SCK low must each last ≥ `SYNC_STAGES`+2 clk; max SCK ≈ 25/8 MHz at default.
  - The first SCK rise must come ≥ 4 clk after CSX falls.
  - CSX must stay low ≥ 4 clk after the last SCK fall.
- `SDO` changes 4 clk after the SCK falling pin edge. The initiator samples it on the next rising edge.
- Register reads are combinational from state flops; writes take effect on the clock edge where `load`=1.

## Test plan
- Reset, then read `out` -> 16'h8000; `SDO_OE`=0; `SDO`=1.
- Write 16'h00A5, then frame 1 byte with initiator sending 8'h3C -> initiator receives A5; `out`=16'h003C (frame active clears after CSX rises); TX pending=0.
- 3-byte frame with no TX load, host clearing after each byte -> initiator receives FF FF FF; `out[7:0]` tracks each byte; no overrun.
- Send 8'h11 then 8'h22 without clearing -> `out`=16'h2011 (overrun set, byte 11 kept); write 16'h0100 -> `out`=16'h8011.
- Raise CSX after 5 bits of 8'hF0 -> RX empty stays 1; next full frame sending 8'h5A reads 16'h005A.
- Assert `resetx`=0 at bit 3, release with CSX low -> no bytes captured until CSX rises and falls again; then normal transfer.

Source files
------------

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target exposing one 16-bit memory-mapped register.
// The initiator pins are sampled in the clk domain through synchronizers.
//
// Ports:
//   clk     system clock
//   resetx  asynchronous active-low reset
//   load    register write strobe
//   in      write data: in[8]=1 clears RX status, in[8]=0 loads TX byte in[7:0]
//   out     {rx_empty, frame_active, overrun, tx_pending, 4'b0, rx_byte}
//   SCK     initiator serial clock (idles low)
//   CSX     initiator chip select, active low
//   SDI     initiator-to-target data
//   SDO     target-to-initiator data
//   SDO_OE  tristate enable for SDO, high while a frame is active
module spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        resetx,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  input  logic        SCK,
  input  logic        CSX,
  input  logic        SDI,
  output logic        SDO,
  output logic        SDO_OE
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
  logic                   sck_s, cs_s, sdi_s;
  logic                   sck_d, cs_d;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic [SYNC_STAGES:0]   valid_sr;
  logic                   armed;

  logic                   start, stop, rise_en, fall_en;
  logic [2:0]             bitcnt;
  logic [7:0]             tx_shift, tx_buf, rx_shift, rx_data;
  logic                   tx_pending, rx_empty, overrun;
  logic [7:0]             reload_byte, rx_next;
  logic                   clear, tx_write;
  logic                   unused_in;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  // Synchronizers, edge-detect flops and registered edge pulses.
  always_ff @(posedge clk or negedge resetx) begin
    if (!resetx) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
      valid_sr <= '0;
      armed    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CSX};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI};
      sck_d    <= sck_s;
      cs_d     <= cs_s;
      sck_rise <= sck_s & ~sck_d;
      sck_fall <= ~sck_s & sck_d;
      cs_fall  <= ~cs_s & cs_d;
      cs_rise  <= cs_s & ~cs_d;
      valid_sr <= {valid_sr[SYNC_STAGES-1:0], 1'b1};
      // The chain holds reset values until it has filled with real pin
      // samples; a frame may only start once CSX has genuinely been seen high,
      // so a frame interrupted by reset is not resumed mid-byte.
      armed    <= armed | (valid_sr[SYNC_STAGES] & cs_s & cs_d);
    end
  end

  always_ff @(posedge clk or negedge resetx) begin
    if (!resetx) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    stop    = 1'b0;
    rise_en = 1'b0;
    fall_en = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          start   = 1'b1;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          stop    = 1'b1;
          state_n = IDLE;
        end else begin
          rise_en = sck_rise;
          fall_en = sck_fall;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign reload_byte = tx_pending ? tx_buf : IDLE_BYTE;
  assign rx_next     = {rx_shift[6:0], sdi_s};
  assign clear       = load & in[8];
  assign tx_write    = load & ~in[8];
  assign unused_in   = ^in[15:9];

  // Statement order encodes same-cycle priority: a clear precedes byte
  // completion, and a host TX write lands after any reload of tx_shift.
  always_ff @(posedge clk or negedge resetx) begin
    if (!resetx) begin
      bitcnt     <= '0;
      tx_shift   <= IDLE_BYTE;
      tx_buf     <= IDLE_BYTE;
      tx_pending <= 1'b0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_empty   <= 1'b1;
      overrun    <= 1'b0;
      SDO        <= 1'b1;
      SDO_OE     <= 1'b0;
    end else begin
      if (start) begin
        bitcnt     <= '0;
        tx_shift   <= reload_byte;
        tx_pending <= 1'b0;
        SDO        <= reload_byte[7];
        SDO_OE     <= 1'b1;
      end
      if (stop) begin
        bitcnt <= '0;
        SDO_OE <= 1'b0;
      end
      if (fall_en) begin
        if (bitcnt != 3'd0) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          SDO      <= tx_shift[6];
        end else begin
          tx_shift   <= reload_byte;
          tx_pending <= 1'b0;
          SDO        <= reload_byte[7];
        end
      end
      if (clear) begin
        rx_empty <= 1'b1;
        overrun  <= 1'b0;
      end
      if (rise_en) begin
        rx_shift <= rx_next;
        bitcnt   <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          if (!rx_empty && !clear) begin
            overrun <= 1'b1;
          end else begin
            rx_data  <= rx_next;
            rx_empty <= 1'b0;
          end
        end
      end
      if (tx_write) begin
        tx_buf     <= in[7:0];
        tx_pending <= 1'b1;
      end
    end
  end

  assign out = {rx_empty, (state == ACTIVE), overrun, tx_pending, 4'b0000, rx_data};

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed, self-checking bench for spi_target. Plays the SPI
// initiator on the pins and the host on the register port. Single-byte frames
// come from a vector table; multi-byte frames, partial frames and reset
// mid-frame are hand-written sequences.
module tb_spi_target;

  logic        clk;
  logic        resetx;
  logic        load;
  logic [15:0] din;
  logic [15:0] dout;
  logic        sck, csx, sdi;
  logic        sdo, sdo_oe;

  int checks = 0;
  int errors = 0;

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk    (clk),
    .resetx (resetx),
    .load   (load),
    .in     (din),
    .out    (dout),
    .SCK    (sck),
    .CSX    (csx),
    .SDI    (sdi),
    .SDO    (sdo),
    .SDO_OE (sdo_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_clear;
    logic        do_load;
    logic [7:0]  load_byte;
    logic [7:0]  mosi;
    logic [7:0]  exp_miso;
    logic [15:0] exp_out;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] rx;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [15:0] d);
    wait_clk(1);
    load = 1'b1;
    din  = d;
    wait_clk(1);
    load = 1'b0;
    din  = '0;
  endtask

  // Shift nbits MSB-first; SDO is captured as SCK rises, as the initiator does.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[7-i];
      wait_clk(6);
      sck = 1'b1;
      rxb = {rxb[6:0], sdo};
      wait_clk(6);
      sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    csx = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_end();
    wait_clk(6);
    csx = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 16'h003C};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 8'h81, 8'hFF, 16'h0081};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h22, 8'hFF, 16'h2081};
    vecs[3] = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h00, 16'h00FF};

    resetx = 1'b0; load = 1'b0; din = '0;
    sck = 1'b0; csx = 1'b1; sdi = 1'b0;
    wait_clk(3);
    resetx = 1'b1;
    wait_clk(8);

    check("reset_out", dout, 16'h8000);
    check("reset_oe", {15'd0, sdo_oe}, 16'h0000);
    check("reset_sdo", {15'd0, sdo}, 16'h0001);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_clear) host_write(16'h0100);
      if (vecs[v].do_load) host_write({8'h00, vecs[v].load_byte});
      cs_begin();
      spi_bits(vecs[v].mosi, 8, rx);
      cs_end();
      check($sformatf("vec%0d_miso", v), {8'h00, rx}, {8'h00, vecs[v].exp_miso});
      check($sformatf("vec%0d_out", v), dout, vecs[v].exp_out);
    end

    // Three back-to-back bytes in one frame, host clearing after each.
    host_write(16'h0100);
    cs_begin();
    check("multi_oe", {15'd0, sdo_oe}, 16'h0001);
    for (int b = 1; b <= 3; b++) begin
      spi_bits(8'(b), 8, rx);
      check($sformatf("multi%0d_miso", b), {8'h00, rx}, 16'h00FF);
      check($sformatf("multi%0d_out", b), dout, {8'h40, 8'(b)});
      host_write(16'h0100);
    end
    cs_end();
    check("multi_end_out", dout, 16'h8003);

    // Overrun: second byte discarded, first kept.
    cs_begin();
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    cs_end();
    check("overrun_out", dout, 16'h2011);
    host_write(16'h0100);
    check("overrun_clear", dout, 16'h8011);

    // Partial byte aborted by CSX, then a full frame.
    cs_begin();
    spi_bits(8'hF0, 5, rx);
    cs_end();
    check("partial_out", dout, 16'h8011);
    check("partial_oe", {15'd0, sdo_oe}, 16'h0000);
    cs_begin();
    spi_bits(8'h5A, 8, rx);
    cs_end();
    check("after_partial_out", dout, 16'h005A);

    // Second TX write before consumption replaces the first.
    host_write(16'h0100);
    host_write(16'h0012);
    host_write(16'h0034);
    check("tx_pending_out", dout, 16'h905A);
    cs_begin();
    spi_bits(8'h00, 8, rx);
    cs_end();
    check("tx_overwrite_miso", {8'h00, rx}, 16'h0034);
    check("tx_overwrite_out", dout, 16'h0000);

    // Reset at bit 3, released with CSX still low.
    cs_begin();
    spi_bits(8'hAA, 3, rx);
    resetx = 1'b0;
    wait_clk(3);
    resetx = 1'b1;
    wait_clk(4);
    check("midreset_out", dout, 16'h8000);
    spi_bits(8'hAA, 5, rx);
    spi_bits(8'h3C, 8, rx);
    check("midreset_ignored_out", dout, 16'h8000);
    check("midreset_oe", {15'd0, sdo_oe}, 16'h0000);
    cs_end();
    cs_begin();
    spi_bits(8'h96, 8, rx);
    cs_end();
    check("post_reset_miso", {8'h00, rx}, 16'h00FF);
    check("post_reset_out", dout, 16'h0096);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
